instr_fetch_unit: RTL and testbench

// - Fetch stage upstream of the CPU top: owns the PC, reads 16-bit instructions from instruction memory

---
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, imem req/ack handshake, prefetch queue, redirect flush
module instr_fetch_unit #(
  parameter int              ADDR_W   = 12,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic                       o_imem_req,
  output logic [ADDR_W-1:0]          o_imem_addr,
  input  logic                       i_imem_ack,
  input  logic [15:0]                i_imem_rdata,
  input  logic                       i_redirect_valid,
  input  logic [ADDR_W-1:0]          i_redirect_addr,
  input  logic                       i_instr_ready,
  output logic                       o_instr_valid,
  output logic [15:0]                o_instr_out,
  output logic [ADDR_W-1:0]          o_instr_pc,
  output logic [$clog2(DEPTH):0]     o_q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t              r_state, w_state_next;
  logic                r_req, w_req_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [ADDR_W-1:0]   r_pc, w_pc_next;
  logic [15:0]         r_q_instr [DEPTH];
  logic [ADDR_W-1:0]   r_q_pc    [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_ack, w_push, w_pop, w_space;
  logic [CNT_W-1:0]    w_count_next;

  // An ack only counts while a request is actually outstanding.
  assign w_ack  = i_imem_ack & r_req;
  assign w_push = (r_state == S_WAIT) & w_ack & ~i_redirect_valid;
  assign w_pop  = i_instr_ready & (r_count != '0) & ~i_redirect_valid;

  assign w_count_next = i_redirect_valid ? '0 :
                        r_count + {{(CNT_W-1){1'b0}}, w_push} - {{(CNT_W-1){1'b0}}, w_pop};
  assign w_space      = w_count_next < CNT_W'(DEPTH);

  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_req;
    w_addr_next  = r_addr;
    w_pc_next    = r_pc;
    case (r_state)
      S_IDLE: begin
        if (!i_redirect_valid && w_space) begin
          w_req_next   = 1'b1;
          w_addr_next  = r_pc;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_redirect_valid) begin
          if (w_ack) begin
            w_req_next   = 1'b0;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_DISCARD;
          end
        end else if (w_ack) begin
          w_pc_next = r_addr + 1'b1;
          if (w_space) begin
            w_addr_next = r_addr + 1'b1;
          end else begin
            w_req_next   = 1'b0;
            w_state_next = S_IDLE;
          end
        end
      end
      S_DISCARD: begin
        if (w_ack) begin
          w_req_next   = 1'b0;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_req_next   = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
    if (i_redirect_valid) begin
      w_pc_next = i_redirect_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_req    <= 1'b0;
      r_addr   <= '0;
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_next;
      r_req   <= w_req_next;
      r_addr  <= w_addr_next;
      r_pc    <= w_pc_next;
      r_count <= w_count_next;
      if (i_redirect_valid) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while r_count covers them.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= i_imem_rdata;
      r_q_pc[r_wr_ptr]    <= r_addr;
    end
  end

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_addr;
  assign o_q_count     = r_count;
  assign o_instr_valid = (r_count != '0);
  assign o_instr_out   = o_instr_valid ? r_q_instr[r_rd_ptr] : 16'h0000;
  assign o_instr_pc    = o_instr_valid ? r_q_pc[r_rd_ptr] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ack, rv, rdy;
  logic [11:0] raddr;
  logic [15:0] rdata;
  logic        req, valid;
  logic [11:0] addr, pc;
  logic [15:0] iout;
  logic [2:0]  cnt;

  logic        w_rst, w_ack, w_rdy;
  logic        w_req, w_valid;
  logic [11:0] w_addr, w_pc;
  logic [15:0] w_iout;
  logic [2:0]  w_cnt;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_ack(ack), .i_imem_rdata(rdata),
    .i_redirect_valid(rv), .i_redirect_addr(raddr),
    .i_instr_ready(rdy),
    .o_instr_valid(valid), .o_instr_out(iout), .o_instr_pc(pc), .o_q_count(cnt)
  );

  instr_fetch_unit #(.RESET_PC(12'hFFE)) dut_wrap (
    .i_clk(clk), .i_rst(w_rst),
    .o_imem_req(w_req), .o_imem_addr(w_addr),
    .i_imem_ack(w_ack), .i_imem_rdata(16'h5A5A),
    .i_redirect_valid(1'b0), .i_redirect_addr(12'h000),
    .i_instr_ready(w_rdy),
    .o_instr_valid(w_valid), .o_instr_out(w_iout), .o_instr_pc(w_pc), .o_q_count(w_cnt)
  );

  typedef struct {
    logic        rdy;
    logic        ack;
    logic        rv;
    logic [11:0] raddr;
    logic [15:0] rdata;
    logic        e_req;
    logic [11:0] e_addr;
    logic        e_valid;
    logic [15:0] e_out;
    logic [11:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(logic r, logic a, logic v, logic [11:0] ra, logic [15:0] rd,
                              logic eq, logic [11:0] ea, logic ev, logic [15:0] eo,
                              logic [11:0] ep, logic [2:0] ec);
    vec_t t;
    t.rdy = r; t.ack = a; t.rv = v; t.raddr = ra; t.rdata = rd;
    t.e_req = eq; t.e_addr = ea; t.e_valid = ev; t.e_out = eo; t.e_pc = ep; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic eq, input logic [11:0] ea, input logic ev,
                         input logic [15:0] eo, input logic [11:0] ep, input logic [2:0] ec);
    chk({tag, ".req"},   32'(req),   32'(eq));
    chk({tag, ".addr"},  32'(addr),  32'(ea));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".out"},   32'(iout),  32'(eo));
    chk({tag, ".pc"},    32'(pc),    32'(ep));
    chk({tag, ".cnt"},   32'(cnt),   32'(ec));
  endtask

  initial begin
    logic [11:0] seen [$];
    logic [11:0] exp_wrap [4];

    //          rdy ack rv raddr   rdata     req addr    vld out       pc      cnt
    vecs[0]  = mk(0, 1, 0, 12'h0, 16'hFFFF, 1, 12'h000, 0, 16'h0000, 12'h000, 3'd0);
    vecs[1]  = mk(0, 1, 0, 12'h0, 16'h1000, 1, 12'h001, 1, 16'h1000, 12'h000, 3'd1);
    vecs[2]  = mk(0, 1, 0, 12'h0, 16'h1001, 1, 12'h002, 1, 16'h1000, 12'h000, 3'd2);
    vecs[3]  = mk(0, 1, 0, 12'h0, 16'h1002, 1, 12'h003, 1, 16'h1000, 12'h000, 3'd3);
    vecs[4]  = mk(0, 1, 0, 12'h0, 16'h1003, 0, 12'h003, 1, 16'h1000, 12'h000, 3'd4);
    vecs[5]  = mk(0, 1, 0, 12'h0, 16'hBEEF, 0, 12'h003, 1, 16'h1000, 12'h000, 3'd4);
    vecs[6]  = mk(1, 1, 0, 12'h0, 16'hBEEF, 1, 12'h004, 1, 16'h1001, 12'h001, 3'd3);
    vecs[7]  = mk(1, 1, 0, 12'h0, 16'h1004, 1, 12'h005, 1, 16'h1002, 12'h002, 3'd3);
    vecs[8]  = mk(1, 1, 0, 12'h0, 16'h1005, 1, 12'h006, 1, 16'h1003, 12'h003, 3'd3);
    vecs[9]  = mk(1, 1, 0, 12'h0, 16'h1006, 1, 12'h007, 1, 16'h1004, 12'h004, 3'd3);
    vecs[10] = mk(1, 0, 0, 12'h0, 16'h0000, 1, 12'h007, 1, 16'h1005, 12'h005, 3'd2);
    vecs[11] = mk(1, 1, 1, 12'h100, 16'h1007, 0, 12'h007, 0, 16'h0000, 12'h000, 3'd0);
    vecs[12] = mk(1, 1, 0, 12'h0, 16'hBEEF, 1, 12'h100, 0, 16'h0000, 12'h000, 3'd0);
    vecs[13] = mk(0, 1, 0, 12'h0, 16'h2100, 1, 12'h101, 1, 16'h2100, 12'h100, 3'd1);
    vecs[14] = mk(1, 0, 0, 12'h0, 16'h0000, 1, 12'h101, 0, 16'h0000, 12'h000, 3'd0);
    vecs[15] = mk(0, 0, 1, 12'h200, 16'h0000, 1, 12'h101, 0, 16'h0000, 12'h000, 3'd0);
    vecs[16] = mk(0, 0, 1, 12'h300, 16'h0000, 1, 12'h101, 0, 16'h0000, 12'h000, 3'd0);
    vecs[17] = mk(0, 1, 0, 12'h0, 16'hDEAD, 0, 12'h101, 0, 16'h0000, 12'h000, 3'd0);
    vecs[18] = mk(0, 0, 0, 12'h0, 16'h0000, 1, 12'h300, 0, 16'h0000, 12'h000, 3'd0);
    vecs[19] = mk(0, 1, 0, 12'h0, 16'h2300, 1, 12'h301, 1, 16'h2300, 12'h300, 3'd1);

    exp_wrap[0] = 12'hFFE; exp_wrap[1] = 12'hFFF; exp_wrap[2] = 12'h000; exp_wrap[3] = 12'h001;

    rst = 1; ack = 0; rv = 0; rdy = 0; raddr = '0; rdata = '0;
    w_rst = 1; w_ack = 0; w_rdy = 0;
    tick();
    tick();
    chk_all("reset", 0, 12'h000, 0, 16'h0000, 12'h000, 3'd0);

    rst = 0;
    for (int i = 0; i < 20; i++) begin
      rdy = vecs[i].rdy; ack = vecs[i].ack; rv = vecs[i].rv;
      raddr = vecs[i].raddr; rdata = vecs[i].rdata;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
              vecs[i].e_out, vecs[i].e_pc, vecs[i].e_cnt);
    end

    // Reset while a request is outstanding, with the ack landing during reset.
    rv = 0; rdy = 0; ack = 0; rst = 1;
    tick();
    ack = 1; rdata = 16'h7777;
    tick();
    chk_all("rst_mid", 0, 12'h000, 0, 16'h0000, 12'h000, 3'd0);
    rst = 0;
    tick();
    chk_all("rst_restart", 1, 12'h000, 0, 16'h0000, 12'h000, 3'd0);
    rdata = 16'h1234;
    tick();
    chk_all("rst_first", 1, 12'h001, 1, 16'h1234, 12'h000, 3'd1);
    ack = 0;

    // PC wrap at the top of the address space.
    w_rst = 0; w_ack = 1; w_rdy = 1;
    for (int c = 0; c < 12 && seen.size() < 4; c++) begin
      tick();
      if (w_valid) seen.push_back(w_pc);
    end
    chk("wrap.count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      chk($sformatf("wrap.pc%0d", i), 32'(seen[i]), 32'(exp_wrap[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
